store_size_rmw: RTL and testbench
=================================

# store_size_rmw

Store-path unit that sits directly upstream of data memory, mirroring the load-size stage on the read side. It takes a store request (SW/SH/SB) with an address and the register-B value. For SW it writes the full word. For SH and SB it performs a read-modify-write: it reads the current memory word, replaces the low half-word or low byte with the corresponding low bits of B, and writes the merged word back. It drives the memory address, write-enable and write-data lines and reports completion to the control unit.

## Interface
- READ_LATENCY, 1, cycles from presenting a read address (mem_wr=0) to valid mem_data_in; legal range 1..4
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- store_size_control  input  2  00=SW, 01=SH, 10=SB, 11=reserved
- addr  input  32  store address; passed to memory unchanged
- b_input  input  32  store data (register B)
- mem_data_in  input  32  memory read data
- mem_addr  output  32  memory address (registered)
- mem_wr  output  1  memory write enable (registered)
- mem_data_out  output  32  memory write data (registered)
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse, coincident with done, for a reserved size code

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE with start=1:
  - Latch addr, b_input and store_size_control.
  - mem_addr <= addr.
  - Next state: SW -> WRITE; SH/SB -> READ with wait counter cleared; 11 -> DONE with err flagged.
- IDLE with start=0: hold all outputs (mem_wr=0).
- READ:
  - mem_wr=0; mem_addr holds the latched address.
  - Counter increments each cycle.
  - On the READ_LATENCY-th READ cycle, capture mem_data_in and go to WRITE.
- Merge rules (independent of addr[1:0]):
  - SH: mem_data_out = {read[31:16], B[15:0]}.
  - SB: mem_data_out = {read[31:8], B[7:0]}.
  - SW: mem_data_out = B.
- WRITE: mem_wr=1 for exactly one cycle, mem_data_out stable, mem_addr = latched address. Then go to DONE.
- DONE: done=1 for one cycle (err=1 if reserved), mem_wr=0. Then go to IDLE.
- start outside IDLE is ignored; there is no request queueing.
- A new start may be accepted in the cycle after DONE, i.e. on the cycle busy is first low.
- mem_addr and mem_data_out keep their last values while idle.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - mem_wr=0, mem_addr=0, mem_data_out=0, busy=0, done=0, err=0.
  - Counter and latched registers cleared.
- Reset asserted mid-operation aborts the request: no write is issued after reset rises, even if it coincides with WRITE.
- Let start be accepted at edge t.
  - SW: mem_wr=1 during cycle t+1; done during cycle t+2; busy during cycles t+1..t+2.
  - SH/SB: READ during cycles t+1..t+L (L=READ_LATENCY); mem_data_in sampled at the edge ending cycle t+L; mem_wr=1 during cycle t+L+1; done during cycle t+L+2.
  - Reserved: done=err=1 during cycle t+1; no write.
- mem_wr is never high in two consecutive cycles.
- mem_wr is never high in the same cycle as done.

## Test plan
- Reset check: during reset, and after release with start=0, every output reads 0 and busy=0.
- SW: start with addr=0x0000_0040, B=0xDEAD_BEEF, size=00 -> one cycle later mem_wr=1, mem_addr=0x40, mem_data_out=0xDEADBEEF; done the following cycle.
- SH, L=1: memory word 0x1122_3344, B=0xAAAA_5566 -> READ for 1 cycle, then write 0x1122_5566; done at t+3.
- SB, L=3: memory word 0x1122_3344, B=0x0000_00FF -> mem_wr stays 0 for 3 cycles, then write 0x1122_33FF; done at t+5. Repeat with start pulsed during busy -> the extra start is ignored.
- Reserved code 11: done=err=1 at t+1; mem_wr stays 0 throughout. Back-to-back SW accepted in the next cycle -> completes normally with err=0.
- Reset mid-op: SH with L=2, assert reset during the second READ cycle -> mem_wr never rises, state returns to IDLE, and a subsequent SW completes normally.

Source files
------------

// File: rtl/store_size_rmw.sv
// store_size_rmw
// Store-path unit in front of data memory. SW writes the whole word directly;
// SH/SB read the current word, merge the low half-word/byte of B into it and
// write the merged word back. Completion is reported with a one-cycle done
// pulse; a reserved size code completes immediately with err and no write.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   start               request strobe, sampled only in IDLE
//   store_size_control  00=SW, 01=SH, 10=SB, 11=reserved
//   addr                store address, passed to memory unchanged
//   b_input             store data (register B)
//   mem_data_in         memory read data
//   mem_addr            memory address (registered)
//   mem_wr              memory write enable (registered)
//   mem_data_out        memory write data (registered)
//   busy                high in every non-IDLE state
//   done                one-cycle completion pulse
//   err                 one-cycle pulse with done for a reserved size code
//
// state | meaning
// IDLE  | waiting for start; outputs hold, mem_wr=0
// READ  | waiting READ_LATENCY cycles for the read word (SH/SB)
// WRITE | mem_wr=1 for this single cycle
// DONE  | done (and err for reserved code) pulse
module store_size_rmw #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_size_control,
  input  logic [31:0] addr,
  input  logic [31:0] b_input,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_data_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  // Counter value seen in the last READ cycle (counter starts at 0).
  localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [1:0]  size_q, size_n;
  logic [31:0] b_q, b_n;
  logic [31:0] addr_n, data_n;
  logic        wr_n, done_n, err_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      size_q       <= 2'd0;
      b_q          <= 32'd0;
      mem_addr     <= 32'd0;
      mem_wr       <= 1'b0;
      mem_data_out <= 32'd0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      size_q       <= size_n;
      b_q          <= b_n;
      mem_addr     <= addr_n;
      mem_wr       <= wr_n;
      mem_data_out <= data_n;
      done         <= done_n;
      err          <= err_n;
    end
  end

  // Output registers are loaded one edge ahead so that mem_wr/done/err are
  // high exactly during the WRITE/DONE cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    size_n  = size_q;
    b_n     = b_q;
    addr_n  = mem_addr;
    data_n  = mem_data_out;
    wr_n    = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          size_n = store_size_control;
          b_n    = b_input;
          addr_n = addr;
          cnt_n  = 2'd0;
          case (store_size_control)
            SZ_WORD: begin
              wr_n    = 1'b1;
              data_n  = b_input;
              state_n = WRITE;
            end
            SZ_HALF, SZ_BYTE: state_n = READ;
            default: begin
              done_n  = 1'b1;
              err_n   = 1'b1;
              state_n = DONE;
            end
          endcase
        end
      end
      READ: begin
        if (cnt == LAST) begin
          wr_n    = 1'b1;
          data_n  = (size_q == SZ_HALF) ? {mem_data_in[31:16], b_q[15:0]}
                                        : {mem_data_in[31:8],  b_q[7:0]};
          state_n = WRITE;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      WRITE: begin
        done_n  = 1'b1;
        state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_store_size_rmw.sv
// Directed bench for store_size_rmw. Three instances (READ_LATENCY 1, 2, 3)
// share all inputs; each is checked against its own expected cycle timing.
module tb_store_size_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  store_size_control;
  logic [31:0] addr, b_input, mem_data_in;

  logic [31:0] ma  [3];
  logic        wr  [3];
  logic [31:0] mdo [3];
  logic        bsy [3];
  logic        dn  [3];
  logic        er  [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    store_size_rmw #(.READ_LATENCY(g + 1)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .store_size_control(store_size_control),
      .addr(addr),
      .b_input(b_input),
      .mem_data_in(mem_data_in),
      .mem_addr(ma[g]),
      .mem_wr(wr[g]),
      .mem_data_out(mdo[g]),
      .busy(bsy[g]),
      .done(dn[g]),
      .err(er[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s L%0d addr", tag, k + 1), ma[k], 32'd0);
      chk($sformatf("%s L%0d wr", tag, k + 1), {31'd0, wr[k]}, 32'd0);
      chk($sformatf("%s L%0d data", tag, k + 1), mdo[k], 32'd0);
      chk($sformatf("%s L%0d busy", tag, k + 1), {31'd0, bsy[k]}, 32'd0);
      chk($sformatf("%s L%0d done", tag, k + 1), {31'd0, dn[k]}, 32'd0);
      chk($sformatf("%s L%0d err", tag, k + 1), {31'd0, er[k]}, 32'd0);
    end
  endtask

  // SH/SB request on all three instances; instance with latency L must write
  // during cycle L+1 and pulse done during cycle L+2 after the accepting edge.
  task automatic run_rmw(input string tag, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_data, input bit pulse);
    addr = a; b_input = b; store_size_control = sz; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      for (int k = 0; k < 3; k++) begin
        int L;
        L = k + 1;
        chk($sformatf("%s L%0d c%0d wr", tag, L, c), {31'd0, wr[k]}, {31'd0, c == L + 1});
        chk($sformatf("%s L%0d c%0d done", tag, L, c), {31'd0, dn[k]}, {31'd0, c == L + 2});
        chk($sformatf("%s L%0d c%0d busy", tag, L, c), {31'd0, bsy[k]}, {31'd0, c <= L + 2});
        chk($sformatf("%s L%0d c%0d err", tag, L, c), {31'd0, er[k]}, 32'd0);
        if (c == L + 1) begin
          chk($sformatf("%s L%0d data", tag, L), mdo[k], exp_data);
          chk($sformatf("%s L%0d addr", tag, L), ma[k], a);
        end
      end
      if (pulse && c == 2) begin
        start = 1'b1; addr = 32'hFFF0; b_input = 32'h0; store_size_control = 2'b00;
      end else begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  task automatic run_sw(input string tag, input logic [31:0] a, input logic [31:0] b);
    addr = a; b_input = b; store_size_control = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s L%0d wr", tag, k + 1), {31'd0, wr[k]}, 32'd1);
      chk($sformatf("%s L%0d addr", tag, k + 1), ma[k], a);
      chk($sformatf("%s L%0d data", tag, k + 1), mdo[k], b);
      chk($sformatf("%s L%0d busy1", tag, k + 1), {31'd0, bsy[k]}, 32'd1);
      chk($sformatf("%s L%0d done1", tag, k + 1), {31'd0, dn[k]}, 32'd0);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s L%0d wr2", tag, k + 1), {31'd0, wr[k]}, 32'd0);
      chk($sformatf("%s L%0d done2", tag, k + 1), {31'd0, dn[k]}, 32'd1);
      chk($sformatf("%s L%0d err2", tag, k + 1), {31'd0, er[k]}, 32'd0);
      chk($sformatf("%s L%0d busy2", tag, k + 1), {31'd0, bsy[k]}, 32'd1);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s L%0d busy3", tag, k + 1), {31'd0, bsy[k]}, 32'd0);
      chk($sformatf("%s L%0d done3", tag, k + 1), {31'd0, dn[k]}, 32'd0);
      chk($sformatf("%s L%0d hold addr", tag, k + 1), ma[k], a);
      chk($sformatf("%s L%0d hold data", tag, k + 1), mdo[k], b);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; store_size_control = 2'b00;
    addr = 32'd0; b_input = 32'd0; mem_data_in = 32'h1122_3344;
    #1;
    chk_idle_zero("in reset");
    tick(); tick();
    #2 reset = 1'b0;
    tick();
    chk_idle_zero("after reset");

    run_sw("sw", 32'h0000_0040, 32'hDEAD_BEEF);

    run_rmw("sh", 2'b01, 32'h0000_0080, 32'hAAAA_5566, 32'h1122_5566, 1'b0);
    run_rmw("sb", 2'b10, 32'h0000_0084, 32'h0000_00FF, 32'h1122_33FF, 1'b0);
    run_rmw("sb pulse", 2'b10, 32'h0000_0088, 32'h0000_00FF, 32'h1122_33FF, 1'b1);

    // Reserved code, then SW accepted on the first non-busy cycle.
    addr = 32'h0000_00C0; b_input = 32'h1234_5678; store_size_control = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rsv L%0d done", k + 1), {31'd0, dn[k]}, 32'd1);
      chk($sformatf("rsv L%0d err", k + 1), {31'd0, er[k]}, 32'd1);
      chk($sformatf("rsv L%0d wr", k + 1), {31'd0, wr[k]}, 32'd0);
      chk($sformatf("rsv L%0d busy", k + 1), {31'd0, bsy[k]}, 32'd1);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rsv L%0d busy2", k + 1), {31'd0, bsy[k]}, 32'd0);
      chk($sformatf("rsv L%0d err2", k + 1), {31'd0, er[k]}, 32'd0);
      chk($sformatf("rsv L%0d wr2", k + 1), {31'd0, wr[k]}, 32'd0);
    end
    run_sw("b2b sw", 32'h0000_0100, 32'hCAFE_F00D);

    // Reset during the second READ cycle of the latency-2 instance.
    addr = 32'h0000_0200; b_input = 32'h0000_ABCD; store_size_control = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk_idle_zero("mid-op reset");
    tick();
    #2 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("post reset c%0d L%0d wr", c, k + 1), {31'd0, wr[k]}, 32'd0);
        chk($sformatf("post reset c%0d L%0d busy", c, k + 1), {31'd0, bsy[k]}, 32'd0);
      end
    end
    run_sw("sw after reset", 32'h0000_0300, 32'h0BAD_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
